cache_ctrl: RTL and testbench

- Direct-mapped, write-through, no-write-allocate cache controller for the CPU side of the 2 KB byte-wide RAM.
- Acts as the initiator on the RAM interface: drives address, write data and write enable, and samples RAM read data.
- The RAM read path is combinational and its write is registered on clk, so each RAM read or write takes one cycle.
- 16 lines of 4 bytes each. Address split: tag[10:6], index[5:2], offset[1:0].

---
 rtl/cache_ctrl.sv | 168 ++++++++++++++++
 tb/tb_cache_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/cache_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : cache_ctrl
//  Brief    : Direct-mapped, write-through, no-write-allocate byte cache
//             sitting between a CPU request port and a single-cycle RAM.
//  Revision : 1.0
// ============================================================================

module cache_ctrl #(
  parameter int ADDR_W   = 11,
  parameter int DATA_W   = 8,
  parameter int INDEX_W  = 4,
  parameter int OFFSET_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_din,
  output logic [DATA_W-1:0] cpu_dout,
  output logic              cpu_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_dout,
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count
);

  localparam int c_TAG_W = ADDR_W - INDEX_W - OFFSET_W;
  localparam int c_LINES = 1 << INDEX_W;
  localparam int c_BYTES = 1 << (INDEX_W + OFFSET_W);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOOKUP = 3'd1,
    ST_REFILL = 3'd2,
    ST_WRITE  = 3'd3,
    ST_RESP   = 3'd4
  } state_t;

  state_t r_state;
  state_t w_next;

  logic                r_req_wr;
  logic [ADDR_W-1:0]   r_req_addr;
  logic [DATA_W-1:0]   r_req_din;
  logic [OFFSET_W-1:0] r_cnt;
  logic                r_wr_hit;
  logic [c_LINES-1:0]  r_valid;
  logic [c_TAG_W-1:0]  r_tag  [c_LINES];
  logic [DATA_W-1:0]   r_data [c_BYTES];
  logic [DATA_W-1:0]   r_dout;
  logic [15:0]         r_hit_cnt;
  logic [15:0]         r_miss_cnt;

  logic [c_TAG_W-1:0]  w_req_tag;
  logic [INDEX_W-1:0]  w_req_idx;
  logic [OFFSET_W-1:0] w_req_off;
  logic                w_hit;
  logic                w_last;

  assign w_req_tag = r_req_addr[ADDR_W-1 -: c_TAG_W];
  assign w_req_idx = r_req_addr[OFFSET_W +: INDEX_W];
  assign w_req_off = r_req_addr[OFFSET_W-1:0];
  assign w_hit     = r_valid[w_req_idx] && (r_tag[w_req_idx] == w_req_tag);
  assign w_last    = (r_cnt == {OFFSET_W{1'b1}});

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    cpu_ready = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_din   = '0;
    case (r_state)
      ST_IDLE: begin
        if (cpu_req) w_next = ST_LOOKUP;
      end
      ST_LOOKUP: begin
        if (r_req_wr)   w_next = ST_WRITE;
        else if (w_hit) w_next = ST_RESP;
        else            w_next = ST_REFILL;
      end
      ST_REFILL: begin
        // Whole line fetched from offset 0, never crossing the line boundary.
        mem_addr = {w_req_tag, w_req_idx, r_cnt};
        if (w_last) w_next = ST_RESP;
      end
      ST_WRITE: begin
        mem_addr = r_req_addr;
        mem_din  = r_req_din;
        mem_wr   = 1'b1;
        w_next   = ST_RESP;
      end
      ST_RESP: begin
        cpu_ready = 1'b1;
        w_next    = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_req_wr   <= 1'b0;
      r_req_addr <= '0;
      r_req_din  <= '0;
      r_cnt      <= '0;
      r_wr_hit   <= 1'b0;
      r_valid    <= '0;
      r_dout     <= '0;
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cpu_req) begin
            r_req_wr   <= cpu_wr;
            r_req_addr <= cpu_addr;
            r_req_din  <= cpu_din;
          end
        end
        ST_LOOKUP: begin
          r_wr_hit <= w_hit;
          r_cnt    <= '0;
          if (w_hit) begin
            if (r_hit_cnt != 16'hFFFF) r_hit_cnt <= r_hit_cnt + 16'd1;
          end else begin
            if (r_miss_cnt != 16'hFFFF) r_miss_cnt <= r_miss_cnt + 16'd1;
          end
          if (!r_req_wr && w_hit) r_dout <= r_data[{w_req_idx, w_req_off}];
        end
        ST_REFILL: begin
          if (r_cnt == w_req_off) r_dout <= mem_dout;
          r_cnt <= r_cnt + OFFSET_W'(1);
          if (w_last) r_valid[w_req_idx] <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Tag and data storage is intentionally left uninitialised; valid bits gate it.
  always_ff @(posedge clk) begin
    if (r_state == ST_REFILL) begin
      r_data[{w_req_idx, r_cnt}] <= mem_dout;
      if (w_last) r_tag[w_req_idx] <= w_req_tag;
    end else if (r_state == ST_WRITE && r_wr_hit) begin
      r_data[{w_req_idx, w_req_off}] <= r_req_din;
    end
  end

  assign cpu_dout   = r_dout;
  assign hit_count  = r_hit_cnt;
  assign miss_count = r_miss_cnt;

endmodule

`default_nettype wire

// File: tb/tb_cache_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cache_ctrl
//  Brief    : Self-checking bench for cache_ctrl against a behavioural cache
//             model with a byte RAM preloaded as mem[a] = a[7:0].
//  Revision : 1.0
// ============================================================================

module tb_cache_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req;
  logic        cpu_wr;
  logic [10:0] cpu_addr;
  logic [7:0]  cpu_din;
  logic [7:0]  cpu_dout;
  logic        cpu_ready;
  logic [10:0] mem_addr;
  logic [7:0]  mem_din;
  logic        mem_wr;
  logic [7:0]  mem_dout;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  cache_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_wr     (cpu_wr),
    .cpu_addr   (cpu_addr),
    .cpu_din    (cpu_din),
    .cpu_dout   (cpu_dout),
    .cpu_ready  (cpu_ready),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .mem_wr     (mem_wr),
    .mem_dout   (mem_dout),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 clk = ~clk;

  logic [7:0] ram [0:2047];
  assign mem_dout = ram[mem_addr];

  initial begin
    for (int a = 0; a < 2048; a++) ram[a] = 8'(a);
    forever begin
      @(posedge clk);
      if (mem_wr) ram[mem_addr] <= mem_din;
    end
  end

  // Behavioural model: contents of RAM, which lines are resident, counters.
  logic [7:0] m_ram   [0:2047];
  bit         m_valid [16];
  logic [4:0] m_tag   [16];
  int         m_hits;
  int         m_misses;
  logic [7:0] m_dout;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    m_hits   = 0;
    m_misses = 0;
    m_dout   = 8'h00;
  endtask

  // One CPU transaction, checked every cycle from request to response.
  // hold keeps cpu_req high for a back-to-back follow-up; pre adds the
  // RESP->IDLE edge when the previous call held the request.
  task automatic do_req(input logic wr, input logic [10:0] addr, input logic [7:0] din,
                        input bit hold, input bit pre);
    int         idx;
    logic [4:0] tag;
    bit         hit;
    int         lat;
    logic [10:0] base;
    idx  = int'(addr[5:2]);
    tag  = addr[10:6];
    hit  = m_valid[idx] && (m_tag[idx] == tag);
    lat  = wr ? 3 : (hit ? 2 : 6);
    base = {addr[10:2], 2'b00};
    if (hit) m_hits   = (m_hits   < 65535) ? m_hits + 1   : m_hits;
    else     m_misses = (m_misses < 65535) ? m_misses + 1 : m_misses;
    if (wr) begin
      m_ram[addr] = din;
    end else begin
      m_dout = m_ram[addr];
      if (!hit) begin
        m_valid[idx] = 1'b1;
        m_tag[idx]   = tag;
      end
    end

    cpu_req  = 1'b1;
    cpu_wr   = wr;
    cpu_addr = addr;
    cpu_din  = din;
    if (pre) begin
      @(posedge clk); @(negedge clk);
      chk("ready_low_in_idle", {31'd0, cpu_ready}, 32'd0);
    end
    for (int k = 1; k <= lat; k++) begin
      @(posedge clk); @(negedge clk);
      if (k == 1 && !hold) cpu_req = 1'b0;
      chk("ready", {31'd0, cpu_ready}, (k == lat) ? 32'd1 : 32'd0);
      chk("mem_wr", {31'd0, mem_wr}, (wr && k == 2) ? 32'd1 : 32'd0);
      if (wr && k == 2) begin
        chk("wr_addr", {21'd0, mem_addr}, {21'd0, addr});
        chk("wr_din", {24'd0, mem_din}, {24'd0, din});
      end
      if (!wr && !hit && k >= 2 && k <= 5)
        chk("refill_addr", {21'd0, mem_addr}, {21'd0, base + 11'(k - 2)});
    end
    chk("dout", {24'd0, cpu_dout}, {24'd0, m_dout});
    chk("hit_count", {16'd0, hit_count}, 32'(m_hits));
    chk("miss_count", {16'd0, miss_count}, 32'(m_misses));
    if (!hold) begin
      @(posedge clk); @(negedge clk);
      chk("ready_one_cycle", {31'd0, cpu_ready}, 32'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        rw;
    logic [10:0] ra;
    logic [7:0]  rd;
    for (int a = 0; a < 2048; a++) m_ram[a] = 8'(a);
    model_reset();
    reset    = 1'b1;
    cpu_req  = 1'b0;
    cpu_wr   = 1'b0;
    cpu_addr = '0;
    cpu_din  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'd0, cpu_ready}, 32'd0);
    chk("rst_dout", {24'd0, cpu_dout}, 32'd0);
    chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    chk("rst_mem_addr", {21'd0, mem_addr}, 32'd0);
    chk("rst_mem_din", {24'd0, mem_din}, 32'd0);
    chk("rst_hits", {16'd0, hit_count}, 32'd0);
    chk("rst_misses", {16'd0, miss_count}, 32'd0);
    reset = 1'b0;

    // Directed sequence with literal pins on the model.
    do_req(1'b0, 11'h005, 8'h00, 1'b0, 1'b0);
    chk("t1_dout", {24'd0, cpu_dout}, 32'h05);
    chk("t1_miss", {16'd0, miss_count}, 32'd1);
    do_req(1'b0, 11'h006, 8'h00, 1'b0, 1'b0);
    chk("t2_dout", {24'd0, cpu_dout}, 32'h06);
    chk("t2_hit", {16'd0, hit_count}, 32'd1);
    do_req(1'b1, 11'h006, 8'hA5, 1'b0, 1'b0);
    chk("t3_dout_held", {24'd0, cpu_dout}, 32'h06);
    do_req(1'b0, 11'h006, 8'h00, 1'b0, 1'b0);
    chk("t3_read_back", {24'd0, cpu_dout}, 32'hA5);
    do_req(1'b0, 11'h045, 8'h00, 1'b0, 1'b0);
    chk("t4_conflict", {24'd0, cpu_dout}, 32'h45);
    do_req(1'b0, 11'h005, 8'h00, 1'b0, 1'b0);
    chk("t4_evicted", {24'd0, cpu_dout}, 32'h05);
    chk("t4_miss", {16'd0, miss_count}, 32'd3);
    do_req(1'b1, 11'h100, 8'h3C, 1'b0, 1'b0);
    do_req(1'b0, 11'h100, 8'h00, 1'b0, 1'b0);
    chk("t5_no_alloc", {24'd0, cpu_dout}, 32'h3C);
    chk("t5_miss", {16'd0, miss_count}, 32'd5);
    do_req(1'b0, 11'h101, 8'h00, 1'b1, 1'b0);
    do_req(1'b0, 11'h102, 8'h00, 1'b0, 1'b1);
    chk("b2b_dout", {24'd0, cpu_dout}, 32'h02);
    do_req(1'b0, 11'h7FE, 8'h00, 1'b0, 1'b0);
    chk("top_line", {24'd0, cpu_dout}, 32'hFE);

    // Reset during REFILL with the line counter at 2.
    cpu_req  = 1'b1;
    cpu_wr   = 1'b0;
    cpu_addr = 11'h200;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); @(negedge clk);
      if (k == 1) cpu_req = 1'b0;
    end
    chk("t6_cnt2_addr", {21'd0, mem_addr}, 32'h202);
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("t6_ready", {31'd0, cpu_ready}, 32'd0);
    chk("t6_mem_wr", {31'd0, mem_wr}, 32'd0);
    chk("t6_mem_addr", {21'd0, mem_addr}, 32'd0);
    chk("t6_hits", {16'd0, hit_count}, 32'd0);
    chk("t6_misses", {16'd0, miss_count}, 32'd0);
    reset = 1'b0;
    model_reset();
    do_req(1'b0, 11'h200, 8'h00, 1'b0, 1'b0);
    chk("t6_refill", {16'd0, miss_count}, 32'd1);
    do_req(1'b0, 11'h203, 8'h00, 1'b0, 1'b0);
    chk("t6_line_valid", {16'd0, hit_count}, 32'd1);

    // Random traffic over a few tags per index so hits, misses and conflicts mix.
    for (int i = 0; i < 300; i++) begin
      rw = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 7) == 0) ra = 11'h7FC + 11'($urandom_range(0, 3));
      else ra = 11'(($urandom_range(0, 3) << 6) | $urandom_range(0, 63));
      rd = 8'($urandom);
      do_req(rw, ra, rd, 1'b0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
